// File: rtl/nw_pkg.sv
// Shared types, state encoding and saturating arithmetic for the
// Needleman-Wunsch systolic scorer.
package nw_pkg;

  localparam int NPE_D      = 16;
  localparam int MAX_TLEN_D = 1024;
  localparam int LW_D       = 11;
  localparam int CWIDTH_D   = 2;
  localparam int SWIDTH_D   = 16;

  typedef logic signed [SWIDTH_D-1:0] score_t;
  typedef logic [CWIDTH_D-1:0]        char_t;

  localparam score_t SMAX = score_t'((1 << (SWIDTH_D - 1)) - 1);
  localparam score_t SMIN = score_t'(-(1 << (SWIDTH_D - 1)));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  // Adds two sign-extended operands and clamps to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/nw_systolic_scorer_if.sv
// Job/config/stream bus of the systolic scorer.
// Handshake: a character transfers on a rising clk edge where in_valid && in_ready;
// in_char must be stable while in_valid is high and not yet accepted.
interface nw_systolic_scorer_if #(
  parameter int LW     = 11,
  parameter int CWIDTH = 2,
  parameter int SWIDTH = 16
);
  logic signed [SWIDTH-1:0] cfg_match;
  logic signed [SWIDTH-1:0] cfg_mismatch;
  logic signed [SWIDTH-1:0] cfg_indel;
  logic                     start;
  logic [LW-1:0]            q_len;
  logic [LW-1:0]            t_len;
  logic                     in_valid;
  logic [CWIDTH-1:0]        in_char;
  logic                     in_ready;
  logic                     busy;
  logic signed [SWIDTH-1:0] score;
  logic                     score_valid;
  logic                     err;
  logic [2:0]               dbg_state;

  modport master (
    output cfg_match, cfg_mismatch, cfg_indel, start, q_len, t_len, in_valid, in_char,
    input  in_ready, busy, score, score_valid, err, dbg_state
  );

  modport slave (
    input  cfg_match, cfg_mismatch, cfg_indel, start, q_len, t_len, in_valid, in_char,
    output in_ready, busy, score, score_valid, err, dbg_state
  );
endinterface

// File: rtl/nw_pe.sv
// One processing element: holds a query character and column score H(j-1,k+1),
// consumes tokens carrying H(j,k)/H(j-1,k) and emits H(j,k+1)/H(j-1,k+1).
module nw_pe
  import nw_pkg::*;
#(
  parameter int CWIDTH = 2,
  parameter int SWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_load,
  input  logic [CWIDTH-1:0]        i_load_c,
  input  logic signed [SWIDTH-1:0] i_load_up,
  input  logic signed [SWIDTH-1:0] i_match,
  input  logic signed [SWIDTH-1:0] i_mismatch,
  input  logic signed [SWIDTH-1:0] i_indel,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic [CWIDTH-1:0]        i_c,
  input  logic signed [SWIDTH-1:0] i_left,
  input  logic signed [SWIDTH-1:0] i_diag,
  output logic                     o_valid,
  output logic                     o_last,
  output logic [CWIDTH-1:0]        o_c,
  output logic signed [SWIDTH-1:0] o_left,
  output logic signed [SWIDTH-1:0] o_diag
);

  function automatic logic signed [SWIDTH-1:0] sadd(input logic signed [SWIDTH-1:0] a,
                                                    input logic signed [SWIDTH-1:0] b);
    logic signed [31:0] r;
    r = sat_add(32'(a), 32'(b), SWIDTH);
    return r[SWIDTH-1:0];
  endfunction

  logic [CWIDTH-1:0]        r_qc;
  logic signed [SWIDTH-1:0] r_up;
  logic                     r_valid;
  logic                     r_last;
  logic [CWIDTH-1:0]        r_c;
  logic signed [SWIDTH-1:0] r_left;
  logic signed [SWIDTH-1:0] r_diag;

  logic signed [SWIDTH-1:0] w_sub;
  logic signed [SWIDTH-1:0] w_d;
  logic signed [SWIDTH-1:0] w_u;
  logic signed [SWIDTH-1:0] w_l;
  logic signed [SWIDTH-1:0] w_h;

  // Tie order diag > up > left falls out of the >= comparisons.
  always_comb begin
    w_sub = (i_c == r_qc) ? i_match : i_mismatch;
    w_d   = sadd(i_diag, w_sub);
    w_u   = sadd(r_up, i_indel);
    w_l   = sadd(i_left, i_indel);
    if (w_d >= w_u && w_d >= w_l) w_h = w_d;
    else if (w_u >= w_l)          w_h = w_u;
    else                          w_h = w_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qc    <= '0;
      r_up    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_c     <= '0;
      r_left  <= '0;
      r_diag  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_valid <= i_valid;
        r_last  <= i_valid & i_last;
      end
      if (i_load) begin
        r_qc <= i_load_c;
        r_up <= i_load_up;
      end else if (i_valid && !i_flush) begin
        r_up   <= w_h;
        r_left <= w_h;
        r_diag <= r_up;
        r_c    <= i_c;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_c     = r_c;
  assign o_left  = r_left;
  assign o_diag  = r_diag;

endmodule

// File: rtl/nw_systolic_scorer.sv
// Streaming Needleman-Wunsch scorer: job FSM, boundary-score counters and
// an NPE-long chain of nw_pe cells fed through a token injection register.
module nw_systolic_scorer
  import nw_pkg::*;
#(
  parameter int NPE      = 16,
  parameter int MAX_TLEN = 1024,
  parameter int LW       = 11,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16
) (
  input logic                 clk,
  input logic                 rst,
  nw_systolic_scorer_if.slave bus
);

  localparam int IW = (NPE > 1) ? $clog2(NPE) : 1;

  function automatic logic signed [SWIDTH-1:0] sadd(input logic signed [SWIDTH-1:0] a,
                                                    input logic signed [SWIDTH-1:0] b);
    logic signed [31:0] r;
    r = sat_add(32'(a), 32'(b), SWIDTH);
    return r[SWIDTH-1:0];
  endfunction

  state_e                   r_state, w_next;
  logic signed [SWIDTH-1:0] r_match, r_mismatch, r_indel;
  logic signed [SWIDTH-1:0] r_gap, r_up_acc, r_score;
  logic [LW-1:0]            r_qlen, r_tlen, r_cnt;
  logic                     r_inj_valid, r_inj_last;
  logic [CWIDTH-1:0]        r_inj_c;
  logic signed [SWIDTH-1:0] r_inj_left, r_inj_diag;

  logic w_in_ready, w_busy, w_err, w_score_valid;
  logic w_accept, w_bad, w_start, w_flush, w_load_en, w_last_out;
  logic signed [SWIDTH-1:0] w_gap_next, w_up_next, w_last_h;
  logic [IW-1:0]            w_last_idx;

  logic                     w_pv [NPE];
  logic                     w_pl [NPE];
  logic [CWIDTH-1:0]        w_pc [NPE];
  logic signed [SWIDTH-1:0] w_ph [NPE];
  logic signed [SWIDTH-1:0] w_pd [NPE];

  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_bad      = (bus.q_len == '0) || (bus.q_len > LW'(NPE)) ||
                      (bus.t_len == '0) || (bus.t_len > LW'(MAX_TLEN));
  assign w_start    = (r_state == S_IDLE) && bus.start;
  assign w_flush    = w_start && !w_bad;
  assign w_load_en  = (r_state == S_LOAD) && w_accept;
  assign w_gap_next = sadd(r_gap, r_indel);
  assign w_up_next  = sadd(r_up_acc, r_indel);
  assign w_last_idx = IW'(r_qlen - LW'(1));
  assign w_last_out = w_pv[w_last_idx] & w_pl[w_last_idx];
  assign w_last_h   = w_ph[w_last_idx];

  always_comb begin
    w_next        = r_state;
    w_in_ready    = 1'b0;
    w_busy        = (r_state != S_IDLE);
    w_err         = 1'b0;
    w_score_valid = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = w_bad ? S_ERR : S_LOAD;
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && r_cnt == r_qlen - LW'(1)) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && r_cnt == r_tlen - LW'(1)) w_next = S_DRAIN;
      end
      S_DRAIN:  if (w_last_out) w_next = S_DONE;
      S_DONE: begin
        w_score_valid = 1'b1;
        w_next        = S_IDLE;
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Target char j enters with left = j*indel and diag = (j-1)*indel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match     <= '0;
      r_mismatch  <= '0;
      r_indel     <= '0;
      r_qlen      <= '0;
      r_tlen      <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_up_acc    <= '0;
      r_score     <= '0;
      r_inj_valid <= 1'b0;
      r_inj_last  <= 1'b0;
      r_inj_c     <= '0;
      r_inj_left  <= '0;
      r_inj_diag  <= '0;
    end else begin
      r_inj_valid <= (r_state == S_STREAM) && w_accept;
      r_inj_last  <= (r_state == S_STREAM) && w_accept && (r_cnt == r_tlen - LW'(1));
      if (w_start) begin
        r_match    <= bus.cfg_match;
        r_mismatch <= bus.cfg_mismatch;
        r_indel    <= bus.cfg_indel;
        r_qlen     <= bus.q_len;
        r_tlen     <= bus.t_len;
        r_cnt      <= '0;
        r_gap      <= '0;
        r_up_acc   <= '0;
      end
      if (w_load_en) begin
        r_cnt    <= (r_cnt == r_qlen - LW'(1)) ? '0 : r_cnt + LW'(1);
        r_up_acc <= w_up_next;
      end
      if ((r_state == S_STREAM) && w_accept) begin
        r_cnt      <= r_cnt + LW'(1);
        r_gap      <= w_gap_next;
        r_inj_c    <= bus.in_char;
        r_inj_left <= w_gap_next;
        r_inj_diag <= r_gap;
      end
      if ((r_state == S_DRAIN) && w_last_out) r_score <= w_last_h;
    end
  end

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    logic                     w_iv, w_il;
    logic [CWIDTH-1:0]        w_ic;
    logic signed [SWIDTH-1:0] w_ileft, w_idiag;
    if (k == 0) begin : g_head
      assign w_iv    = r_inj_valid;
      assign w_il    = r_inj_last;
      assign w_ic    = r_inj_c;
      assign w_ileft = r_inj_left;
      assign w_idiag = r_inj_diag;
    end else begin : g_body
      assign w_iv    = w_pv[k-1];
      assign w_il    = w_pl[k-1];
      assign w_ic    = w_pc[k-1];
      assign w_ileft = w_ph[k-1];
      assign w_idiag = w_pd[k-1];
    end
    nw_pe #(.CWIDTH(CWIDTH), .SWIDTH(SWIDTH)) u_pe (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (w_flush),
      .i_load     (w_load_en && (r_cnt == LW'(k))),
      .i_load_c   (bus.in_char),
      .i_load_up  (w_up_next),
      .i_match    (r_match),
      .i_mismatch (r_mismatch),
      .i_indel    (r_indel),
      .i_valid    (w_iv),
      .i_last     (w_il),
      .i_c        (w_ic),
      .i_left     (w_ileft),
      .i_diag     (w_idiag),
      .o_valid    (w_pv[k]),
      .o_last     (w_pl[k]),
      .o_c        (w_pc[k]),
      .o_left     (w_ph[k]),
      .o_diag     (w_pd[k])
    );
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.busy        = w_busy;
  assign bus.err         = w_err;
  assign bus.score_valid = w_score_valid;
  assign bus.score       = r_score;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_nw_systolic_scorer.sv
// Directed bench for nw_systolic_scorer: a 16-bit instance and a 4-bit
// saturation instance driven in lockstep from the same stimulus.
module tb_nw_systolic_scorer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] cfg_match = '0, cfg_mismatch = '0, cfg_indel = '0;
  logic               start = 1'b0;
  logic [10:0]        q_len = '0, t_len = '0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_char = '0;

  logic [1:0] qa [16];
  logic [1:0] ta [16];

  int total = 0;
  int bad   = 0;

  nw_systolic_scorer_if #(.LW(11), .CWIDTH(2), .SWIDTH(16)) bus0 ();
  nw_systolic_scorer_if #(.LW(11), .CWIDTH(2), .SWIDTH(4))  bus1 ();

  assign bus0.cfg_match    = cfg_match;
  assign bus0.cfg_mismatch = cfg_mismatch;
  assign bus0.cfg_indel    = cfg_indel;
  assign bus0.start        = start;
  assign bus0.q_len        = q_len;
  assign bus0.t_len        = t_len;
  assign bus0.in_valid     = in_valid;
  assign bus0.in_char      = in_char;
  assign bus1.cfg_match    = cfg_match[3:0];
  assign bus1.cfg_mismatch = cfg_mismatch[3:0];
  assign bus1.cfg_indel    = cfg_indel[3:0];
  assign bus1.start        = start;
  assign bus1.q_len        = q_len;
  assign bus1.t_len        = t_len;
  assign bus1.in_valid     = in_valid;
  assign bus1.in_char      = in_char;

  nw_systolic_scorer #(.NPE(16), .MAX_TLEN(1024), .LW(11), .CWIDTH(2), .SWIDTH(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  nw_systolic_scorer #(.NPE(16), .MAX_TLEN(1024), .LW(11), .CWIDTH(2), .SWIDTH(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sequences are packed two bits per char, first char in the LSBs.
  task automatic set_seqs(input logic [31:0] qv, input logic [31:0] tv);
    for (int i = 0; i < 16; i++) begin
      qa[i] = qv[2*i +: 2];
      ta[i] = tv[2*i +: 2];
    end
  endtask

  task automatic set_w(input int m, input int mm, input int g);
    cfg_match    = 16'(m);
    cfg_mismatch = 16'(mm);
    cfg_indel    = 16'(g);
  endtask

  task automatic send_char(input logic [1:0] c, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_char  = c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.in_ready && n < 20);
    check("in_ready", 32'(bus0.in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int ql, input int tl);
    @(posedge clk); #1;
    q_len = 11'(ql);
    t_len = 11'(tl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input int ql, input int tl, input bit gap,
                         input int exp0, input bit chk1, input int exp1);
    int k0, k1, np0, np1;
    @(negedge clk);
    check({tag, "_idle"}, 32'(bus0.busy), 0);
    pulse_start(ql, tl);
    for (int i = 0; i < ql; i++) send_char(qa[i], gap);
    for (int i = 0; i < tl; i++) send_char(ta[i], gap);
    k0 = -1; k1 = -1; np0 = 0; np1 = 0;
    for (int k = 0; k < ql + 6; k++) begin
      @(negedge clk);
      if (bus0.score_valid) begin np0++; if (k0 < 0) k0 = k; end
      if (bus1.score_valid) begin np1++; if (k1 < 0) k1 = k; end
    end
    check({tag, "_latency"}, k0, ql + 1);
    check({tag, "_pulses"}, np0, 1);
    check({tag, "_score"}, bus0.score, exp0);
    if (chk1) begin
      check({tag, "_latency4"}, k1, ql + 1);
      check({tag, "_score4"}, bus1.score, exp1);
    end
  endtask

  task automatic bad_start(input string tag, input int ql, input int tl, input int held);
    pulse_start(ql, tl);
    @(negedge clk);
    check({tag, "_err"}, 32'(bus0.err), 1);
    check({tag, "_sv"}, 32'(bus0.score_valid), 0);
    @(negedge clk);
    check({tag, "_err_drop"}, 32'(bus0.err), 0);
    check({tag, "_busy"}, 32'(bus0.busy), 0);
    check({tag, "_sv2"}, 32'(bus0.score_valid), 0);
    check({tag, "_held"}, bus0.score, held);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_ready", 32'(bus0.in_ready), 0);
    check("rst_sv", 32'(bus0.score_valid), 0);
    check("rst_err", 32'(bus0.err), 0);
    check("rst_score", bus0.score, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // test 1: ACGT vs ACGT, 1/-1/-1
    set_w(1, -1, -1);
    set_seqs(32'he4, 32'he4);
    run_job("t1", 4, 4, 1'b0, 4, 1'b0, 0);

    // test 2: all mismatches and uneven lengths
    set_seqs(32'h00, 32'hff);
    run_job("t2a", 4, 4, 1'b0, -4, 1'b0, 0);
    set_seqs(32'h4, 32'h0);
    run_job("t2b", 2, 1, 1'b0, 0, 1'b0, 0);
    set_seqs(32'h0, 32'h4);
    run_job("t2c", 1, 2, 1'b0, 0, 1'b0, 0);

    // different weights: q=AC t=CA, 2/-1/-2
    set_w(2, -1, -2);
    set_seqs(32'h4, 32'h1);
    run_job("t2d", 2, 2, 1'b0, -2, 1'b1, -2);

    // test 3: bubbles on alternate cycles
    set_w(1, -1, -1);
    set_seqs(32'he4, 32'he4);
    run_job("t3", 4, 4, 1'b1, 4, 1'b0, 0);

    // test 4: saturation on the 4-bit instance
    set_w(7, -1, -1);
    set_seqs(32'h00, 32'h00);
    run_job("t4", 4, 4, 1'b0, 28, 1'b1, 7);

    // test 5: rejected starts
    bad_start("t5_q0", 0, 4, 28);
    bad_start("t5_qbig", 17, 4, 28);
    bad_start("t5_t0", 4, 0, 28);

    // test 6: reset in the middle of streaming
    set_w(1, -1, -1);
    set_seqs(32'he4, 32'he4);
    pulse_start(4, 4);
    for (int i = 0; i < 4; i++) send_char(qa[i], 1'b0);
    for (int i = 0; i < 2; i++) send_char(ta[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 32'(bus0.busy), 0);
    check("t6_ready", 32'(bus0.in_ready), 0);
    check("t6_sv", 32'(bus0.score_valid), 0);
    check("t6_err", 32'(bus0.err), 0);
    check("t6_score", bus0.score, 0);
    check("t6_score4", bus1.score, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_job("t6_rerun", 4, 4, 1'b0, 4, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
